// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle between the two Avalon-MM requesters, the arbiter and the
// single-port on-chip memory macro.
// The slave modport is the arbiter's view: it is the slave of both requesters
// and the master of the memory. The master modport is the opposite side,
// used by whatever drives the requests and models the memory.
interface onchip_mem_arbiter_if #(
  parameter int AW = 14
);
  // Port 0: CPU instruction/data path (read-only)
  logic          p0_read;
  logic          p0_write;
  logic [AW-1:0] p0_address;
  logic          p0_waitrequest;
  logic [31:0]   p0_readdata;
  logic          p0_readdatavalid;
  logic [7:0]    p0_wr_err_cnt;

  // Port 1: boot loader / debug path (read/write)
  logic          p1_read;
  logic          p1_write;
  logic [AW-1:0] p1_address;
  logic [3:0]    p1_byteenable;
  logic [31:0]   p1_writedata;
  logic          p1_waitrequest;
  logic [31:0]   p1_readdata;
  logic          p1_readdatavalid;

  // Memory macro side
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect;
  logic          mem_write;
  logic          mem_debugaccess;
  logic [31:0]   mem_writedata;
  logic          mem_clken;
  logic [31:0]   mem_readdata;

  modport slave (
    input  p0_read, p0_write, p0_address,
    output p0_waitrequest, p0_readdata, p0_readdatavalid, p0_wr_err_cnt,
    input  p1_read, p1_write, p1_address, p1_byteenable, p1_writedata,
    output p1_waitrequest, p1_readdata, p1_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
           mem_debugaccess, mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport master (
    output p0_read, p0_write, p0_address,
    input  p0_waitrequest, p0_readdata, p0_readdatavalid, p0_wr_err_cnt,
    output p1_read, p1_write, p1_address, p1_byteenable, p1_writedata,
    input  p1_waitrequest, p1_readdata, p1_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
           mem_debugaccess, mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 32-bit on-chip RAM.
// Port 0 (CPU) is read-only: its writes are accepted but dropped and counted.
// Port 1 (boot/debug) may read and write; its in-range writes are forwarded
// with debugaccess set so the macro honours them.
// Reads have a fixed one-cycle latency, so a small tag register replaces any
// response queue: it remembers who issued the read and whether it was out of
// range, and steers the memory output back to that port on the next cycle.
module onchip_mem_arbiter #(
  parameter int unsigned DEPTH    = 10240,
  parameter int          AW       = 14,
  parameter logic [31:0] OOR_DATA = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 reset,
  onchip_mem_arbiter_if.slave bus
);

  // Request decode
  logic rd0, wr0, req0;
  logic rd1, wr1, req1;
  logic in_range0, in_range1;

  // Arbitration result
  logic gnt0, gnt1;

  // State
  logic       last_grant_q, last_grant_d;
  logic       tag_valid_q, tag_valid_d;
  logic       tag_port_q, tag_port_d;
  logic       tag_oor_q, tag_oor_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [31:0] p0_rdata_q, p0_rdata_d;
  logic [31:0] p1_rdata_q, p1_rdata_d;

  // Response path
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        p0_rdv, p1_rdv;

  // Read wins when a master illegally raises read and write together
  assign rd0  = bus.p0_read;
  assign wr0  = bus.p0_write & ~bus.p0_read;
  assign req0 = bus.p0_read | bus.p0_write;
  assign rd1  = bus.p1_read;
  assign wr1  = bus.p1_write & ~bus.p1_read;
  assign req1 = bus.p1_read | bus.p1_write;

  assign in_range0 = ({{(32-AW){1'b0}}, bus.p0_address} < DEPTH);
  assign in_range1 = ({{(32-AW){1'b0}}, bus.p1_address} < DEPTH);

  // Round-robin grant: on a tie the port that did not win last time goes
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && (!req1 || last_grant_q)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Only a requesting loser is stalled; idle ports never see waitrequest
  assign bus.p0_waitrequest = req0 & ~gnt0;
  assign bus.p1_waitrequest = req1 & ~gnt1;

  // Memory drive for the granted access; dropped accesses keep chipselect low
  always_comb begin
    bus.mem_address     = '0;
    bus.mem_byteenable  = 4'h0;
    bus.mem_chipselect  = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_debugaccess = 1'b0;
    bus.mem_writedata   = 32'h0;
    if (gnt0) begin
      bus.mem_address    = bus.p0_address;
      bus.mem_byteenable = 4'hF;
      bus.mem_chipselect = rd0 & in_range0;
    end else if (gnt1) begin
      bus.mem_address     = bus.p1_address;
      bus.mem_byteenable  = bus.p1_byteenable;
      bus.mem_writedata   = bus.p1_writedata;
      bus.mem_chipselect  = in_range1;
      bus.mem_write       = wr1 & in_range1;
      bus.mem_debugaccess = wr1 & in_range1;
    end
  end

  assign bus.mem_clken = 1'b1;

  // Response steering; reset suppresses a response that was already in flight
  assign rsp_valid = tag_valid_q & ~reset;
  assign rsp_data  = tag_oor_q ? OOR_DATA : bus.mem_readdata;
  assign p0_rdv    = rsp_valid & ~tag_port_q;
  assign p1_rdv    = rsp_valid & tag_port_q;

  assign bus.p0_readdatavalid = p0_rdv;
  assign bus.p1_readdatavalid = p1_rdv;
  assign bus.p0_readdata      = p0_rdv ? rsp_data : p0_rdata_q;
  assign bus.p1_readdata      = p1_rdv ? rsp_data : p1_rdata_q;
  assign bus.p0_wr_err_cnt    = err_cnt_q;

  // Next-state: grant history, read tag, dropped-write counter, held readdata
  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt0) begin
      last_grant_d = 1'b0;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
    end

    tag_valid_d = (gnt0 & rd0) | (gnt1 & rd1);
    tag_port_d  = gnt1;
    tag_oor_d   = gnt1 ? ~in_range1 : ~in_range0;

    err_cnt_d = err_cnt_q;
    if (gnt0 && wr0 && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    p0_rdata_d = p0_rdv ? rsp_data : p0_rdata_q;
    p1_rdata_d = p1_rdv ? rsp_data : p1_rdata_q;
  end

  // State registers with synchronous reset; port 0 wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      tag_valid_q  <= 1'b0;
      tag_port_q   <= 1'b0;
      tag_oor_q    <= 1'b0;
      err_cnt_q    <= 8'h00;
      p0_rdata_q   <= 32'h0;
      p1_rdata_q   <= 32'h0;
    end else begin
      last_grant_q <= last_grant_d;
      tag_valid_q  <= tag_valid_d;
      tag_port_q   <= tag_port_d;
      tag_oor_q    <= tag_oor_d;
      err_cnt_q    <= err_cnt_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Testbench for onchip_mem_arbiter: directed requests, a behavioural RAM, and
// a scoreboard of expected read responses (data plus arrival cycle) per port.
module tb_onchip_mem_arbiter;

  localparam int          AW       = 14;
  localparam int          DEPTH    = 10240;
  localparam logic [31:0] OOR_DATA = 32'h0000_0000;

  typedef struct {
    logic [31:0] data;
    int          cycle;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] mem_array [0:DEPTH-1];

  onchip_mem_arbiter_if #(.AW(AW)) bus();

  onchip_mem_arbiter #(.DEPTH(DEPTH), .AW(AW), .OOR_DATA(OOR_DATA)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Power-up contents: a recognisable address pattern, 0x100 starts all ones
  function automatic logic [31:0] init_word(logic [13:0] a);
    if (a == 14'h0100) return 32'hFFFF_FFFF;
    return {8'hA5, 10'h000, a};
  endfunction

  // Behavioural single-port RAM, one-cycle registered read
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_array[i] <= init_word(14'(i));
    end else if (bus.mem_chipselect && (int'(bus.mem_address) < DEPTH)) begin
      if (bus.mem_write && bus.mem_debugaccess) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_byteenable[b])
            mem_array[bus.mem_address][b*8 +: 8] <= bus.mem_writedata[b*8 +: 8];
        end
      end
      bus.mem_readdata <= mem_array[bus.mem_address];
    end
  end

  function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endfunction

  // Monitor: every readdatavalid must match the oldest expected response
  always @(negedge clk) begin
    exp_t e;
    if (bus.p0_readdatavalid) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL p0_unexpected_rdv: got strobe at cycle %0d, expected none", cyc);
      end else begin
        e = q0.pop_front();
        checkOutput("p0_readdata", bus.p0_readdata, e.data);
        checkOutput("p0_rdv_cycle", cyc, e.cycle);
      end
    end
    if (bus.p1_readdatavalid) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL p1_unexpected_rdv: got strobe at cycle %0d, expected none", cyc);
      end else begin
        e = q1.pop_front();
        checkOutput("p1_readdata", bus.p1_readdata, e.data);
        checkOutput("p1_rdv_cycle", cyc, e.cycle);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] timeout");
  end

  // Drive one cycle of requests, then wait to the sampling point mid-cycle
  task automatic applyStimulus(input logic r0, input logic w0, input logic [AW-1:0] a0,
                               input logic r1, input logic w1, input logic [AW-1:0] a1,
                               input logic [3:0] be1, input logic [31:0] wd1);
    bus.p0_read       = r0;
    bus.p0_write      = w0;
    bus.p0_address    = a0;
    bus.p1_read       = r1;
    bus.p1_write      = w1;
    bus.p1_address    = a1;
    bus.p1_byteenable = be1;
    bus.p1_writedata  = wd1;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void expect_rd(int port, logic [31:0] data);
    exp_t e;
    e.data  = data;
    e.cycle = cyc + 1;
    if (port == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  initial begin
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    int g;

    reset = 1'b1;
    bus.mem_readdata = 32'h0;
    idle();
    step();
    idle();
    checkOutput("reset_clken", 32'(bus.mem_clken), 32'h1);
    checkOutput("reset_cs", 32'(bus.mem_chipselect), 32'h0);
    checkOutput("reset_errcnt", 32'(bus.p0_wr_err_cnt), 32'h0);
    step();
    reset = 1'b0;

    // Port 0 read alone
    applyStimulus(1'b1, 1'b0, 14'h0010, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    checkOutput("t1_p0_wait", 32'(bus.p0_waitrequest), 32'h0);
    checkOutput("t1_cs", 32'(bus.mem_chipselect), 32'h1);
    checkOutput("t1_addr", 32'(bus.mem_address), 32'h0010);
    checkOutput("t1_be", 32'(bus.mem_byteenable), 32'hF);
    expect_rd(0, init_word(14'h0010));
    step();
    idle();
    checkOutput("t1_p1_quiet", 32'(bus.p1_readdatavalid), 32'h0);
    step();

    // Port 1 read alone, which also leaves port 1 as the last grant
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 14'h0030, 4'hF, 32'h0);
    checkOutput("t1b_p1_wait", 32'(bus.p1_waitrequest), 32'h0);
    expect_rd(1, init_word(14'h0030));
    step();

    // Both read continuously: grants alternate starting with port 0
    a0 = 14'h0020;
    a1 = 14'h0040;
    for (int i = 0; i < 6; i++) begin
      g = i % 2;
      applyStimulus(1'b1, 1'b0, a0, 1'b1, 1'b0, a1, 4'hF, 32'h0);
      checkOutput("t2_p0_wait", 32'(bus.p0_waitrequest), (g == 0) ? 32'h0 : 32'h1);
      checkOutput("t2_p1_wait", 32'(bus.p1_waitrequest), (g == 1) ? 32'h0 : 32'h1);
      checkOutput("t2_addr", 32'(bus.mem_address), (g == 0) ? 32'(a0) : 32'(a1));
      if (g == 0) begin
        expect_rd(0, init_word(a0));
        a0 = a0 + 1'b1;
      end else begin
        expect_rd(1, init_word(a1));
        a1 = a1 + 1'b1;
      end
      step();
    end
    idle();
    step();

    // Partial write from port 1, then read back
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 14'h0100, 4'b0011, 32'hA5A5_1234);
    checkOutput("t3_wr_wait", 32'(bus.p1_waitrequest), 32'h0);
    checkOutput("t3_wr_memwrite", 32'(bus.mem_write), 32'h1);
    checkOutput("t3_wr_dbg", 32'(bus.mem_debugaccess), 32'h1);
    checkOutput("t3_wr_be", 32'(bus.mem_byteenable), 32'h3);
    step();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 14'h0100, 4'hF, 32'h0);
    checkOutput("t3_rd_dbg", 32'(bus.mem_debugaccess), 32'h0);
    checkOutput("t3_rd_memwrite", 32'(bus.mem_write), 32'h0);
    expect_rd(1, 32'hFFFF_1234);
    step();
    // Read and write together: read wins, memory untouched
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 14'h0100, 4'hF, 32'h0000_0000);
    checkOutput("t3_rw_memwrite", 32'(bus.mem_write), 32'h0);
    expect_rd(1, 32'hFFFF_1234);
    step();

    // Port 0 writes are swallowed and counted
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 14'h0050, 1'b0, 1'b0, '0, 4'h0, 32'h0);
      checkOutput("t4_cs", 32'(bus.mem_chipselect), 32'h0);
      checkOutput("t4_wait", 32'(bus.p0_waitrequest), 32'h0);
      step();
    end
    idle();
    checkOutput("t4_cnt3", 32'(bus.p0_wr_err_cnt), 32'h3);
    step();
    for (int i = 3; i < 254; i++) begin
      applyStimulus(1'b0, 1'b1, 14'h0050, 1'b0, 1'b0, '0, 4'h0, 32'h0);
      step();
    end
    idle();
    checkOutput("t4_cnt254", 32'(bus.p0_wr_err_cnt), 32'hFE);
    step();
    for (int i = 254; i < 300; i++) begin
      applyStimulus(1'b0, 1'b1, 14'h0050, 1'b0, 1'b0, '0, 4'h0, 32'h0);
      step();
    end
    idle();
    checkOutput("t4_cnt_sat", 32'(bus.p0_wr_err_cnt), 32'hFF);
    step();

    // Out-of-range read and write on port 1
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 14'h2800, 4'hF, 32'h0);
    checkOutput("t5_rd_cs", 32'(bus.mem_chipselect), 32'h0);
    checkOutput("t5_rd_wait", 32'(bus.p1_waitrequest), 32'h0);
    expect_rd(1, OOR_DATA);
    step();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 14'h2800, 4'hF, 32'hDEAD_BEEF);
    checkOutput("t5_wr_cs", 32'(bus.mem_chipselect), 32'h0);
    checkOutput("t5_wr_memwrite", 32'(bus.mem_write), 32'h0);
    checkOutput("t5_wr_dbg", 32'(bus.mem_debugaccess), 32'h0);
    step();

    // Read in flight when reset arrives is discarded
    applyStimulus(1'b1, 1'b0, 14'h0010, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    checkOutput("t6_p0_wait", 32'(bus.p0_waitrequest), 32'h0);
    step();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 14'h0010, 4'hF, 32'h0);
    checkOutput("t6_rdv_in_reset", 32'(bus.p0_readdatavalid), 32'h0);
    checkOutput("t6_cs_in_reset", 32'(bus.mem_chipselect), 32'h0);
    checkOutput("t6_clken_in_reset", 32'(bus.mem_clken), 32'h1);
    step();
    idle();
    checkOutput("t6_cnt_cleared", 32'(bus.p0_wr_err_cnt), 32'h0);
    checkOutput("t6_rdv_after", 32'(bus.p0_readdatavalid), 32'h0);
    step();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 14'h0011, 1'b1, 1'b0, 14'h0012, 4'hF, 32'h0);
    checkOutput("t6_tie_p0_wait", 32'(bus.p0_waitrequest), 32'h0);
    checkOutput("t6_tie_p1_wait", 32'(bus.p1_waitrequest), 32'h1);
    expect_rd(0, init_word(14'h0011));
    step();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 14'h0012, 4'hF, 32'h0);
    checkOutput("t6_p1_wait", 32'(bus.p1_waitrequest), 32'h0);
    expect_rd(1, init_word(14'h0012));
    step();
    idle();
    step();
    idle();
    step();

    checkOutput("q0_drained", 32'(q0.size()), 32'h0);
    checkOutput("q1_drained", 32'(q1.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
Shares the single-port 32-bit on-chip memory (10240 words, 14-bit word address, byte enables, writes honoured only with debugaccess) between two Avalon-MM requesters. Port 0 is the CPU instruction/data path and is read-only. Port 1 is the boot loader/debug path and is read/write. The block sits between the two masters and the memory macro. It provides round-robin arbitration, the waitrequest/readdatavalid handshake, address range checking and write filtering.

Parameters:
DEPTH, 10240, number of implemented 32-bit words; a word address >= DEPTH is out of range.
AW, 14, word address width.
OOR_DATA, 32'h0000_0000, readdata returned for out-of-range reads.

Ports:
clk  in  1  single clock for all logic and the memory.
reset  in  1  synchronous, active-high reset.
p0_read  in  1  port 0 read request.
p0_write  in  1  port 0 write request; never forwarded to the memory.
p0_address  in  AW  port 0 word address.
p0_waitrequest  out  1  high = port 0 request not accepted this cycle.
p0_readdata  out  32  port 0 read data.
p0_readdatavalid  out  1  port 0 read data valid strobe.
p1_read / p1_write  in  1 / 1  port 1 read and write requests.
p1_address  in  AW  port 1 word address.
p1_byteenable  in  4  port 1 byte lanes.
p1_writedata  in  32  port 1 write data.
p1_waitrequest  out  1  high = port 1 request not accepted this cycle.
p1_readdata  out  32  port 1 read data.
p1_readdatavalid  out  1  port 1 read data valid strobe.
mem_address  out  AW  to memory.
mem_byteenable  out  4  to memory.
mem_chipselect / mem_write / mem_debugaccess  out  1 each  to memory.
mem_writedata  out  32  to memory.
mem_clken  out  1  memory clock enable; constant 1 after reset.
mem_readdata  in  32  memory output, valid 1 cycle after the address is presented.
p0_wr_err_cnt  out  8  saturating count of dropped port 0 writes.

Behaviour:
- Clocking: one clock domain. Reset is synchronous and active-high. Reset sets last_grant=1 (port 0 wins the first tie), clears all readdatavalid and pipeline tags, and clears p0_wr_err_cnt. Memory outputs are 0 during reset except mem_clken=1.
- Request: a port requests when read|write is high. A port must not assert read and write together; if it does, read wins and the write is ignored.
- Arbitration: combinational, one grant per cycle.
  - Single requester: that port is granted.
  - Both requesting: the port other than last_grant is granted. last_grant updates on every grant.
- Waitrequest: the granted port sees waitrequest=0 and its request is accepted that cycle. A requesting, non-granted port sees waitrequest=1. An idle port sees waitrequest=0.
- Memory drive on a grant:
  - mem_address = granted address.
  - mem_chipselect = 1.
  - Port 0 uses byteenable 4'hF.
  - mem_write = mem_debugaccess = 1 only for an in-range port 1 write; otherwise both are 0.
- Read pipeline:
  - An accepted read registers tag {valid, port, oor}.
  - Next cycle, the tagged port's readdatavalid=1 for exactly one cycle.
  - readdata = mem_readdata, or OOR_DATA if oor.
  - Fixed latency is 1 cycle. Back-to-back reads from alternating ports are allowed every cycle. readdata holds its last value when not valid.
- Out-of-range access (address >= DEPTH): accepted with normal timing. An OOR write is dropped: mem_chipselect=0.
- Port 0 writes: accepted in one cycle and never reach the memory. Each one increments p0_wr_err_cnt, saturating at 8'hFF. Port 0 writes take part in arbitration like any other request.
- Simultaneous events: the readdatavalid of a previous read and a new grant can occur in the same cycle, with no conflict.
- Reset mid-operation: a read in flight is discarded; no readdatavalid follows reset.
- No outstanding-read limit is needed: latency is fixed and responses arrive in order.

Test Plan:
- Reset, then p0_read addr 0x0010 alone -> p0_waitrequest=0 in that cycle; next cycle p0_readdatavalid=1 with p0_readdata=mem[0x10]; p1 outputs quiet.
- p0 and p1 both read continuously for 6 cycles -> grants alternate p0,p1,p0,p1,p0,p1. Each loser sees waitrequest=1. A valid strobe arrives 1 cycle after each grant, to the correct port.
- p1_write addr 0x0100, byteenable 4'b0011, data 0xA5A5_1234 over initial 0xFFFF_FFFF, then p1_read 0x0100 -> readdata 0xFFFF_1234; mem_debugaccess=1 only in the write cycle.
- p0_write issued 3 times -> mem_chipselect=0 in those cycles, p0_wr_err_cnt=3; after 300 writes the counter reads 0xFF.
- p1_read addr 10240 (14'h2800) -> mem_chipselect=0, p1_readdatavalid after 1 cycle with p1_readdata=OOR_DATA; p1_write to the same address leaves memory unchanged.
- p0_read accepted, then reset asserted in the next cycle -> p0_readdatavalid stays 0, p0_wr_err_cnt=0. After reset, a simultaneous request grants port 0 first.
